hebb_trainer: RTL and testbench
===============================

// Module: hebb_trainer
// PURPOSE
//  Upstream stage of the 25-neuron Hopfield recall engine: builds the signed 8-bit link matrix
//  by Hebbian learning from 25-bit bipolar patterns. Streams every updated weight on a write port.
//  That port drives the recall engine's links[] memory.
//  Replaces the static links include file with on-chip training.
// PARAMETERS
//  N       25  neurons per pattern (5x5 matrix); weight count N*N = 625
//  WW      8   weight width, signed two's complement
//  AW      10  weight address width (must satisfy 2^AW >= N*N)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active low
//  clr_req    in   1   one-cycle request: zero all weights (sampled only in IDLE)
//  pat_valid  in   1   pattern offered
//  pat_ready  out  1   pattern accepted when pat_valid && pat_ready
//  pat_data   in   N   pattern; bit=1 -> +1, bit=0 -> -1 (bit k = neuron k, row-major 5x5)
//  w_we       out  1   weight write strobe
//  w_addr     out  AW  weight address k = i*N + j (i = destination neuron, j = source neuron)
//  w_data     out  WW  signed weight value to write
//  busy       out  1   high in CLR or UPD
//  done       out  1   one-cycle pulse after the last write of a CLR or UPD sequence
//  pat_count  out  4   patterns trained since the last clear; saturates at 15
// BEHAVIOUR
//  - Internal weight array: N*N x WW regs, not reset. Read combinationally during UPD.
//  - FSM states: CLR, IDLE, UPD.
//    Reset -> CLR, so weights are always zeroed after rst; no zeros exist before that pass.
//  - Reset values: w_we=0, w_addr=0, w_data=0, done=0, pat_count=0, pat_ready=0, busy=1 (CLR).
//    The step counter resets to 0.
//  - CLR: step k = 0..624, one per clk. Writes 0 to the internal array.
//    Registered outputs w_we=1, w_addr=k, w_data=0 appear one cycle after step k.
//    After step 624 -> IDLE. done pulses in the cycle after the final w_we.
//    pat_count <= 0 on entry to CLR.
//  - IDLE: pat_ready = !clr_req (combinational).
//    clr_req=1 -> CLR. Clear wins over a simultaneous pat_valid, and that pattern is not accepted.
//    pat_valid && pat_ready -> latch pat_data, go to UPD, pat_count += 1 (hold at 15).
//  - UPD: step k = 0..624, i = k / N, j = k % N, tracked as nested counters (no divider).
//    * i==j: new weight = 0 (diagonal forced zero).
//    * otherwise: new weight = w[k] + (pat[i]==pat[j] ? +1 : -1).
//    * The new value is written to the internal array. Registered w_we/w_addr/w_data follow one cycle later.
//    * After k=624 -> IDLE, with done pulsing after the final write.
//  - Write stream: exactly 625 consecutive w_we cycles per CLR or UPD, addresses strictly ascending 0..624.
//    Back-to-back writes have no gaps. No w_we is asserted in IDLE.
//  - Timing: pat_ready is 0 during CLR/UPD. Pattern acceptance to first w_we = 2 cycles.
//    Acceptance to done = 627 cycles.
//  - clr_req outside IDLE is ignored (not queued).
//  - Reset mid-CLR/UPD: immediate abort, partial writes stand, the sequence restarts at CLR step 0.
// CONFIGURATION
//  HEBB_SAT_EN defined: the off-diagonal update saturates to [-127,+127].
//    -128 is never produced, so the recall engine's negation stays exact.
//  HEBB_SAT_EN undefined: the update wraps modulo 2^WW (two's complement), with no clamp logic.
// TESTING
//  1. Release rst -> 625 w_we with w_data=0, w_addr 0..624 ascending.
//     Then done=1 for one cycle, busy=0, pat_count=0.
//  2. Train pattern 25'h1FFFFFF -> every w[i][j] with i!=j = +1, diagonal = 0, pat_count=1.
//  3. Train 25'b0111010011100100001001110 after clear -> w_addr 1 (i=0,j=1) = -1.
//     w_addr 26 (i=1,j=1) = 0; w_addr 27 (i=1,j=2) = +1.
//  4. Train 25'h1FFFFFF 130 times -> w_addr 1 = +127 with HEBB_SAT_EN, -126 without.
//     pat_count = 15 in both cases.
//  5. Assert clr_req and pat_valid together in IDLE -> pat_ready=0, no pattern accepted, CLR runs.
//     Then 625 zero writes follow and pat_count=0.
//  6. Assert rst low at the 300th UPD write -> outputs take their reset values immediately.
//     After release, a full 625-write CLR runs, then IDLE with pat_ready=1.

Source files
------------

// File: rtl/hebb_trainer.sv
// Hebbian trainer: builds the N*N signed link matrix from bipolar patterns and streams each written weight.
// Build option: define HEBB_SAT_EN to clamp off-diagonal updates to [-127,+127]; otherwise they wrap.
module hebb_trainer #(
   parameter int N  = 25,
   parameter int WW = 8,
   parameter int AW = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_req,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [N-1:0]         pat_data,
   output logic                 w_we,
   output logic [AW-1:0]        w_addr,
   output logic signed [WW-1:0] w_data,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           pat_count
);

   localparam int CW = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N*N-1);
   localparam logic [CW-1:0] JLAST = CW'(N-1);
   localparam logic signed [WW-1:0] W_ONE = WW'(1);
`ifdef HEBB_SAT_EN
   localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
   localparam logic signed [WW-1:0] W_MIN = {1'b1, {(WW-2){1'b0}}, 1'b1};
`endif

   typedef enum logic [1:0] {S_CLR, S_IDLE, S_UPD} state_t;

   state_t                r_state;
   logic [AW-1:0]         r_k;
   logic [CW-1:0]         r_i;
   logic [CW-1:0]         r_j;
   logic [N-1:0]          r_pat;
   logic signed [WW-1:0]  r_w [N*N];
   logic                  r_we;
   logic [AW-1:0]         r_addr;
   logic signed [WW-1:0]  r_data;
   logic                  r_done;
   logic [3:0]            r_cnt;

   logic                  w_active;
   logic                  w_accept;
   logic signed [WW-1:0]  w_old;
   logic                  w_same;
   logic signed [WW-1:0]  w_wdata;

   function automatic logic signed [WW-1:0] hebb_step(input logic signed [WW-1:0] old,
                                                      input logic same);
`ifdef HEBB_SAT_EN
      if (same) return (old >= W_MAX) ? W_MAX : old + W_ONE;
      else      return (old <= W_MIN) ? W_MIN : old - W_ONE;
`else
      return same ? old + W_ONE : old - W_ONE;
`endif
   endfunction

   assign w_active  = (r_state != S_IDLE);
   assign w_accept  = (r_state == S_IDLE) && !clr_req && pat_valid;
   assign w_old     = r_w[r_k];
   assign w_same    = (r_pat[r_i] == r_pat[r_j]);

   always_comb begin
      w_wdata = '0;
      if (r_state == S_UPD && r_i != r_j)
         w_wdata = hebb_step(w_old, w_same);
   end

   // Weight store: plain RAM, no reset; zeros only come from a CLR pass.
   always_ff @(posedge clk) begin
      if (rst && w_active)
         r_w[r_k] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (w_accept)
         r_pat <= pat_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_CLR;
         r_k     <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= r_we && (r_addr == LAST);
         case (r_state)
            S_CLR, S_UPD: begin
               r_we   <= 1'b1;
               r_addr <= r_k;
               r_data <= w_wdata;
               if (r_k == LAST) begin
                  r_k     <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_state <= S_IDLE;
               end else begin
                  // Row/column tracked as nested counters so no divider is needed.
                  r_k <= r_k + AW'(1);
                  if (r_j == JLAST) begin
                     r_j <= '0;
                     r_i <= r_i + CW'(1);
                  end else begin
                     r_j <= r_j + CW'(1);
                  end
               end
            end
            S_IDLE: begin
               if (clr_req) begin
                  r_state <= S_CLR;
                  r_cnt   <= '0;
               end else if (pat_valid) begin
                  r_state <= S_UPD;
                  r_cnt   <= (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
               end
            end
            default: r_state <= S_CLR;
         endcase
      end
   end

   assign pat_ready = (r_state == S_IDLE) && !clr_req;
   assign busy      = w_active;
   assign w_we      = r_we;
   assign w_addr    = r_addr;
   assign w_data    = r_data;
   assign done      = r_done;
   assign pat_count = r_cnt;

endmodule

// File: tb/tb_hebb_trainer.sv
// Scoreboard bench for hebb_trainer: a matrix-level Hebbian model queues expected writes, a monitor checks them.
module tb_hebb_trainer;
   localparam int N  = 25;
   localparam int NN = N * N;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              clr_req = 1'b0;
   logic              pat_valid = 1'b0;
   logic [N-1:0]      pat_data = '0;
   logic              pat_ready;
   logic              w_we;
   logic [9:0]        w_addr;
   logic signed [7:0] w_data;
   logic              busy;
   logic              done;
   logic [3:0]        pat_count;

   hebb_trainer #(.N(N), .WW(8), .AW(10)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .pat_valid(pat_valid),
      .pat_ready(pat_ready), .pat_data(pat_data), .w_we(w_we), .w_addr(w_addr),
      .w_data(w_data), .busy(busy), .done(done), .pat_count(pat_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int addr; int data; } wr_t;
   wr_t exp_q[$];
   int  mw[NN];
   int  mcnt = 0;
   int  wr_last[NN];
   int  wr_seen = 0;
   bit  prev_last = 0;
   int  total = 0;
   int  bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int step_w(input int old, input bit same);
      int v;
      v = old + (same ? 1 : -1);
`ifdef HEBB_SAT_EN
      if (v > 127)  v = 127;
      if (v < -127) v = -127;
`else
      if (v > 127)  v -= 256;
      if (v < -128) v += 256;
`endif
      return v;
   endfunction

   task automatic model_clear();
      wr_t e;
      mcnt = 0;
      for (int k = 0; k < NN; k++) begin
         mw[k] = 0;
         e.addr = k; e.data = 0;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_train(input logic [N-1:0] p);
      wr_t e;
      mcnt = (mcnt < 15) ? mcnt + 1 : 15;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int k;
            k = i * N + j;
            mw[k] = (i == j) ? 0 : step_w(mw[k], p[i] == p[j]);
            e.addr = k; e.data = mw[k];
            exp_q.push_back(e);
         end
   endtask

   // Monitor: every write must match the next queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (w_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("w_addr", int'(w_addr), e.addr);
               chk("w_data", int'(w_data), e.data);
            end
            wr_last[w_addr] = int'(w_data);
         end
         if (done) chk("done_after_last_write", int'(prev_last), 1);
         prev_last = w_we && (w_addr == 10'd624);
      end
   end

   task automatic wait_done(output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 3000);
      if (!done) chk("done_timeout", 0, 1);
      at = cyc;
   endtask

   task automatic train(input logic [N-1:0] p, input bit wait_end);
      int a, d;
      @(negedge clk);
      pat_valid = 1'b1;
      pat_data  = p;
      #1 chk("pat_ready_idle", int'(pat_ready), 1);
      a = cyc;
      @(posedge clk);
      model_train(p);
      @(negedge clk);
      pat_valid = 1'b0;
      if (wait_end) begin
         wait_done(d);
         chk("accept_to_done_cycles", d - a, 627);
      end
   endtask

   task automatic clear(input bit with_pat);
      int d;
      @(negedge clk);
      clr_req   = 1'b1;
      pat_valid = with_pat;
      pat_data  = 25'h1FFFFFF;
      #1 chk("pat_ready_during_clr_req", int'(pat_ready), 0);
      @(posedge clk);
      model_clear();
      @(negedge clk);
      clr_req   = 1'b0;
      pat_valid = 1'b0;
      wait_done(d);
   endtask

   initial begin
      int d, base, n;
      logic [N-1:0] p;
      for (int k = 0; k < NN; k++) wr_last[k] = 99;

      // Reset state and the automatic clear pass.
      #1 chk("rst_busy", int'(busy), 1);
      chk("rst_pat_ready", int'(pat_ready), 0);
      chk("rst_w_we", int'(w_we), 0);
      model_clear();
      #22 rst = 1'b1;
      wait_done(d);
      chk("clr_busy", int'(busy), 0);
      chk("clr_pat_count", int'(pat_count), 0);
      chk("clr_pat_ready", int'(pat_ready), 1);
      chk("clr_queue_drained", exp_q.size(), 0);

      // All-ones pattern from zero weights.
      train(25'h1FFFFFF, 1'b1);
      chk("ones_w1", wr_last[1], 1);
      chk("ones_diag0", wr_last[0], 0);
      chk("ones_diag624", wr_last[624], 0);
      chk("ones_pat_count", int'(pat_count), 1);

      // Long random run keeping bits 0 and 1 equal so w[0][1] hits its limit.
      for (int t = 0; t < 127; t++) begin
         p = N'($urandom);
         p[1] = p[0];
         train(p, 1'b1);
      end
`ifdef HEBB_SAT_EN
      chk("limit_w1", wr_last[1], 127);
`else
      chk("limit_w1", wr_last[1], -128);
`endif
      chk("limit_pat_count", int'(pat_count), 15);
      chk("model_pat_count", int'(pat_count), mcnt);

      // Mixed pattern after a clear.
      clear(1'b0);
      chk("clear_pat_count", int'(pat_count), 0);
      train(25'b0111010011100100001001110, 1'b1);
      chk("mixed_w1", wr_last[1], -1);
      chk("mixed_w26", wr_last[26], 0);
      chk("mixed_w27", wr_last[27], 1);

      // Clear and pattern together: clear wins.
      clear(1'b1);
      chk("clrwin_pat_count", int'(pat_count), 0);
      chk("clrwin_w1", wr_last[1], 0);
      chk("clrwin_queue_drained", exp_q.size(), 0);

      // Reset in the middle of an update stream.
      base = wr_seen;
      train(N'($urandom), 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (wr_seen < base + 300 && n < 2000);
      chk("mid_write_count", wr_seen - base, 300);
      rst = 1'b0;
      #1;
      chk("mid_rst_w_we", int'(w_we), 0);
      chk("mid_rst_w_addr", int'(w_addr), 0);
      chk("mid_rst_w_data", int'(w_data), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_pat_count", int'(pat_count), 0);
      chk("mid_rst_pat_ready", int'(pat_ready), 0);
      chk("mid_rst_busy", int'(busy), 1);
      exp_q.delete();
      model_clear();
      base = wr_seen;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      wait_done(d);
      chk("post_rst_writes", wr_seen - base, 625);
      chk("post_rst_pat_ready", int'(pat_ready), 1);
      chk("post_rst_busy", int'(busy), 0);
      chk("final_queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
